// File: rtl/nona_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nona_pkg
//  Description : Shared defaults and types for the nine-core scheduler:
//                core count and data width defaults, a 4-bit core index
//                type and the operand/result data type.
//  Revision    : 1.0  initial release
// ============================================================================
package nona_pkg;

    localparam int c_NUM_CORES = 9;
    localparam int c_DATA_W    = 8;

    typedef logic [3:0]          core_id_t;
    typedef logic [c_DATA_W-1:0] data_t;

endpackage : nona_pkg
`default_nettype wire

// File: rtl/nona_id_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : nona_id_fifo
//  Description : Synchronous FIFO of core indices. It records the issue order
//                so that results can be returned in that order.
//                Push and pop may occur in the same cycle.
//  Ports       : clk, rst    clock, asynchronous active-high reset
//                i_push      write i_data (ignored when full without a pop)
//                i_data      core index to enqueue
//                i_pop       drop the head entry (ignored when empty)
//                o_head      oldest entry
//                o_empty     no entries
//                o_full      DEPTH entries
//  Revision    : 1.0  initial release
// ============================================================================
module nona_id_fifo
    import nona_pkg::*;
#(
    parameter int DEPTH = c_NUM_CORES
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     i_push,
    input  core_id_t i_data,
    input  logic     i_pop,
    output core_id_t o_head,
    output logic     o_empty,
    output logic     o_full
);

    localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW = $clog2(DEPTH + 1);
    localparam logic [c_PW-1:0] c_LAST = c_PW'(DEPTH - 1);

    core_id_t        r_mem [DEPTH];
    logic [c_PW-1:0] r_wr;
    logic [c_PW-1:0] r_rd;
    logic [c_CW-1:0] r_cnt;

    logic w_do_push;
    logic w_do_pop;

    assign o_empty   = (r_cnt == '0);
    assign o_full    = (r_cnt == c_CW'(DEPTH));
    assign o_head    = r_mem[r_rd];
    // A full FIFO may still take a push when the head leaves in the same cycle.
    assign w_do_push = i_push & (~o_full | i_pop);
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= (r_wr == c_LAST) ? '0 : r_wr + c_PW'(1);
            end
            if (w_do_pop) begin
                r_rd <= (r_rd == c_LAST) ? '0 : r_rd + c_PW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_cnt <= r_cnt + c_CW'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_cnt <= r_cnt - c_CW'(1);
            end
        end
    end

endmodule : nona_id_fifo
`default_nettype wire

// File: rtl/nona_core_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : nona_core_scheduler
//  Description : Shares an input byte stream among NUM_CORES processing
//                cores. Each accepted byte goes to a free core chosen
//                round-robin. Results are captured per core and returned
//                in the original issue order.
//  Ports       : clk, reset              clock, asynchronous active-high reset
//                in_data/in_valid/in_ready   operand stream in
//                out_data/out_valid/out_ready result stream out (issue order)
//                core_start/core_operand     one-hot start pulse + shared operand
//                core_busy/core_done/core_result  per-core status and results
//                active_count            cores dispatched and not yet retired
//                err                     sticky protocol-error flag
//  Revision    : 1.0  initial release
// ============================================================================
module nona_core_scheduler
    import nona_pkg::*;
#(
    parameter int NUM_CORES = c_NUM_CORES,
    parameter int DATA_W    = c_DATA_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_W-1:0]           in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NUM_CORES-1:0]        core_start,
    output logic [DATA_W-1:0]           core_operand,
    input  logic [NUM_CORES-1:0]        core_busy,
    input  logic [NUM_CORES-1:0]        core_done,
    input  logic [NUM_CORES*DATA_W-1:0] core_result,
    output logic [3:0]                  active_count,
    output logic                        err
);

    localparam int       c_IW      = $clog2(NUM_CORES);
    localparam core_id_t c_LAST_ID = core_id_t'(NUM_CORES - 1);

    // Registered state
    logic                 r_run;      // low during reset and the first cycle after it
    logic [NUM_CORES-1:0] r_owned;
    logic [NUM_CORES-1:0] r_res_vld;
    logic [NUM_CORES-1:0] r_start;
    logic [DATA_W-1:0]    r_operand;
    logic [DATA_W-1:0]    r_res_reg [NUM_CORES];
    core_id_t             r_rr_ptr;
    logic                 r_err;

    // Combinational
    logic [NUM_CORES-1:0] w_free;
    logic [NUM_CORES-1:0] w_capture;
    logic [NUM_CORES-1:0] w_err_ev;
    logic [NUM_CORES-1:0] w_acc_oh;
    logic [NUM_CORES-1:0] w_pop_oh;
    logic [DATA_W-1:0]    w_result [NUM_CORES];
    logic                 w_accept;
    logic                 w_pop;
    core_id_t             w_pick;
    core_id_t             w_rr_next;
    core_id_t             w_head;
    logic [c_IW-1:0]      w_head_idx;
    logic                 w_fifo_empty;
    logic                 w_fifo_full;
    logic [3:0]           w_active;

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_slice
        assign w_result[g] = core_result[g*DATA_W +: DATA_W];
    end

    assign w_free    = ~r_owned & ~core_busy;
    assign w_capture = core_done & r_owned & ~r_res_vld;
    // A done from an idle core, or a second done before retirement, is dropped.
    assign w_err_ev  = core_done & (~r_owned | r_res_vld);

    // The full term is redundant with |w_free but keeps the FIFO safe by construction.
    assign in_ready  = r_run & (|w_free) & ~w_fifo_full;
    assign w_accept  = in_valid & in_ready;

    // Round-robin pick: scanning from farthest to nearest leaves the first
    // free core at or after r_rr_ptr (with wrap) as the winner.
    always_comb begin
        w_pick = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (w_free[c_IW'((int'(r_rr_ptr) + i) % NUM_CORES)]) begin
                w_pick = core_id_t'((int'(r_rr_ptr) + i) % NUM_CORES);
            end
        end
    end

    assign w_rr_next = (w_pick == c_LAST_ID) ? '0 : w_pick + core_id_t'(1);

    // Retire side: everything here comes from registers, not from inputs.
    assign w_head_idx = c_IW'(w_head);
    assign out_valid  = ~w_fifo_empty & r_res_vld[w_head_idx];
    assign out_data   = r_res_reg[w_head_idx];
    assign w_pop      = out_valid & out_ready;

    always_comb begin
        w_acc_oh = '0;
        w_pop_oh = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            w_acc_oh[k] = w_accept & (w_pick == core_id_t'(k));
            w_pop_oh[k] = w_pop & (w_head == core_id_t'(k));
        end
    end

    always_comb begin
        w_active = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            w_active = w_active + 4'(r_owned[k]);
        end
    end

    nona_id_fifo #(
        .DEPTH (NUM_CORES)
    ) u_order_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_accept),
        .i_data  (w_pick),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    // The accepted core is never the retiring head (head is owned, the pick
    // is free), and a capturing core cannot be retiring (its res_vld is 0),
    // so set and clear masks never collide on the same bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_run     <= 1'b0;
            r_owned   <= '0;
            r_res_vld <= '0;
            r_start   <= '0;
            r_operand <= '0;
            r_rr_ptr  <= '0;
            r_err     <= 1'b0;
            for (int i = 0; i < NUM_CORES; i++) begin
                r_res_reg[i] <= '0;
            end
        end else begin
            r_run     <= 1'b1;
            r_start   <= w_acc_oh;
            r_owned   <= (r_owned | w_acc_oh) & ~w_pop_oh;
            r_res_vld <= (r_res_vld | w_capture) & ~w_pop_oh;
            if (w_accept) begin
                r_operand <= in_data;
                r_rr_ptr  <= w_rr_next;
            end
            for (int i = 0; i < NUM_CORES; i++) begin
                if (w_capture[i]) begin
                    r_res_reg[i] <= w_result[i];
                end
            end
            if (|w_err_ev) begin
                r_err <= 1'b1;
            end
        end
    end

    assign core_start   = r_start;
    assign core_operand = r_operand;
    assign active_count = w_active;
    assign err          = r_err;

endmodule : nona_core_scheduler
`default_nettype wire

// File: tb/tb_nona_core_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_nona_core_scheduler
//  Description : Self-checking bench for nona_core_scheduler. Directed
//                scenarios followed by random traffic, all compared against
//                an issue-order queue model of the scheduler.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_nona_core_scheduler;

    localparam int N = 9;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [7:0]   in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] core_start;
    logic [7:0]   core_operand;
    logic [N-1:0] core_busy = '0;
    logic [N-1:0] core_done = '0;
    logic [N*8-1:0] core_result = '0;
    logic [3:0]   active_count;
    logic         err;

    always #5 clk = ~clk;

    nona_core_scheduler #(.NUM_CORES(N), .DATA_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .core_start   (core_start),
        .core_operand (core_operand),
        .core_busy    (core_busy),
        .core_done    (core_done),
        .core_result  (core_result),
        .active_count (active_count),
        .err          (err)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: ownership, captured results, issue-order queue
    bit         m_owned [N];
    bit         m_vld   [N];
    logic [7:0] m_res   [N];
    int         m_q[$];
    int         m_rr;
    bit         m_err;
    bit         m_run;
    logic [N-1:0] m_start;
    logic [7:0] m_opnd;

    // Core emulation and directed drive
    bit           auto_cores = 1'b0;
    int           tmr [N];
    logic [7:0]   cop [N];
    logic [N-1:0] ext_busy = '0;
    logic [N-1:0] man_done = '0;
    logic [N*8-1:0] man_result = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_owned[k] = 1'b0;
            m_vld[k]   = 1'b0;
            m_res[k]   = '0;
            tmr[k]     = 0;
        end
        m_q.delete();
        m_rr    = 0;
        m_err   = 1'b0;
        m_run   = 1'b0;
        m_start = '0;
        m_opnd  = '0;
    endtask

    function automatic bit exp_in_ready();
        bit any = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!m_owned[k] && !core_busy[k]) any = 1'b1;
        end
        return m_run && any;
    endfunction

    function automatic bit exp_out_valid();
        return (m_q.size() > 0) && m_vld[m_q[0]];
    endfunction

    // Advance the model over one clock edge with the inputs now applied.
    task automatic model_edge();
        bit acc;
        bit ov;
        int pick;
        logic [N-1:0] nstart;
        acc    = in_valid && exp_in_ready();
        ov     = exp_out_valid();
        pick   = -1;
        nstart = '0;
        if (acc) begin
            for (int i = 0; i < N && pick < 0; i++) begin
                int c;
                c = (m_rr + i) % N;
                if (!m_owned[c] && !core_busy[c]) pick = c;
            end
        end
        for (int k = 0; k < N; k++) begin
            if (core_done[k]) begin
                if (!m_owned[k] || m_vld[k]) begin
                    m_err = 1'b1;
                end else begin
                    m_vld[k] = 1'b1;
                    m_res[k] = core_result[k*8 +: 8];
                end
            end
        end
        if (ov && out_ready) begin
            int h;
            h = m_q.pop_front();
            m_owned[h] = 1'b0;
            m_vld[h]   = 1'b0;
        end
        if (acc) begin
            m_owned[pick] = 1'b1;
            m_q.push_back(pick);
            m_rr         = (pick + 1) % N;
            nstart[pick] = 1'b1;
            m_opnd       = in_data;
        end
        m_start = nstart;
        m_run   = 1'b1;
    endtask

    // One clock cycle: drive core inputs, compare all outputs, advance model.
    task automatic cycle();
        if (auto_cores) begin
            for (int k = 0; k < N; k++) begin
                if (m_start[k]) begin
                    tmr[k] = $urandom_range(2, 6);
                    cop[k] = m_opnd;
                end
            end
        end
        core_busy   = ext_busy;
        core_done   = man_done;
        core_result = man_result;
        for (int k = 0; k < N; k++) begin
            if (tmr[k] > 0) begin
                core_busy[k] = 1'b1;
                if (tmr[k] == 1) begin
                    core_done[k]         = 1'b1;
                    core_result[k*8 +: 8] = cop[k] * 8'd3 + 8'(k);
                end
            end
        end
        #1;
        chk("in_ready", 32'(in_ready), 32'(exp_in_ready()));
        chk("out_valid", 32'(out_valid), 32'(exp_out_valid()));
        if (exp_out_valid()) chk("out_data", 32'(out_data), 32'(m_res[m_q[0]]));
        chk("core_start", 32'(core_start), 32'(m_start));
        if (m_start != '0) chk("core_operand", 32'(core_operand), 32'(m_opnd));
        chk("active_count", 32'(active_count), 32'(m_q.size()));
        chk("err", 32'(err), 32'(m_err));
        model_edge();
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (tmr[k] > 0) tmr[k]--;
        end
        man_done = '0;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        ext_busy   = '0;
        man_done   = '0;
        man_result = '0;
        auto_cores = 1'b0;
        core_busy  = '0;
        core_done  = '0;
        core_result = '0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_core_start", 32'(core_start), 32'd0);
        chk("rst_core_operand", 32'(core_operand), 32'd0);
        chk("rst_active_count", 32'(active_count), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle();
    endtask

    task automatic send(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic done_core(input int k, input logic [7:0] r);
        man_done[k]          = 1'b1;
        man_result[k*8 +: 8] = r;
        cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        // Single task
        do_reset();
        send(8'hAA);
        chk("single_start", 32'(core_start), 32'h001);
        chk("single_operand", 32'(core_operand), 32'hAA);
        cycle();
        cycle();
        cycle();
        done_core(0, 8'h55);
        chk("single_out_valid", 32'(out_valid), 32'd1);
        chk("single_out_data", 32'(out_data), 32'h55);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        chk("single_retired", 32'(active_count), 32'd0);

        // Round-robin fill
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < N; i++) begin
            in_data = 8'(i + 1);
            cycle();
            chk("fill_start", 32'(core_start), 32'd1 << i);
            chk("fill_operand", 32'(core_operand), 32'(i + 1));
        end
        in_valid = 1'b0;
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        chk("fill_active", 32'(active_count), 32'd9);
        send(8'hFF);
        chk("fill_no_start", 32'(core_start), 32'd0);
        done_core(0, 8'h77);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        chk("fill_ready_back", 32'(in_ready), 32'd1);
        chk("fill_active_8", 32'(active_count), 32'd8);

        // Reorder
        do_reset();
        out_ready = 1'b1;
        send(8'h10);
        send(8'h20);
        chk("reorder_start1", 32'(core_start), 32'h002);
        cycle();
        done_core(1, 8'hB0);
        chk("reorder_hold", 32'(out_valid), 32'd0);
        cycle();
        cycle();
        done_core(0, 8'hA0);
        chk("reorder_first", 32'(out_data), 32'hA0);
        cycle();
        chk("reorder_second_v", 32'(out_valid), 32'd1);
        chk("reorder_second", 32'(out_data), 32'hB0);
        cycle();
        chk("reorder_empty", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Backpressure, plus a duplicate done that must not overwrite
        do_reset();
        send(8'h33);
        cycle();
        done_core(0, 8'hC3);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_data", 32'(out_data), 32'hC3);
            chk("bp_active", 32'(active_count), 32'd1);
            cycle();
        end
        done_core(0, 8'h5C);
        chk("dup_err", 32'(err), 32'd1);
        chk("dup_kept", 32'(out_data), 32'hC3);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        chk("bp_retired_v", 32'(out_valid), 32'd0);
        chk("bp_retired_cnt", 32'(active_count), 32'd0);

        // Busy skip and wrap: advance rr_ptr to 8 first
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 8'(8'h40 + i);
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        for (int k = 0; k < 8; k++) begin
            man_done[k]          = 1'b1;
            man_result[k*8 +: 8] = 8'(8'h80 + k);
        end
        cycle();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("skip_retire", 32'(out_data), 32'(8'h80 + i));
            cycle();
        end
        out_ready = 1'b0;
        chk("skip_idle", 32'(active_count), 32'd0);
        ext_busy = 9'h101;
        send(8'h44);
        chk("skip_core1", 32'(core_start), 32'h002);
        ext_busy = '0;
        send(8'h45);
        chk("skip_rr2", 32'(core_start), 32'h004);

        // Errors and mid-run reset
        do_reset();
        done_core(4, 8'hEE);
        chk("spurious_err", 32'(err), 32'd1);
        chk("spurious_no_out", 32'(out_valid), 32'd0);
        send(8'h11);
        cycle();
        done_core(0, 8'h99);
        send(8'h12);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_active", 32'(active_count), 32'd0);
        chk("mid_rst_start", 32'(core_start), 32'd0);
        @(posedge clk);
        #1;
        chk("mid_rst_no_start", 32'(core_start), 32'd0);
        chk("mid_rst_no_valid", 32'(out_valid), 32'd0);

        // Random traffic against the model
        do_reset();
        auto_cores = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            ext_busy  = ($urandom_range(0, 7) == 0) ? 9'($urandom) : 9'd0;
            cycle();
        end
        in_valid  = 1'b0;
        ext_busy  = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cycle();
        end
        chk("drain_active", 32'(active_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_nona_core_scheduler
`default_nettype wire
